// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
//   Transmit side of a four-phase req/ack clock-domain crossing. A word is
//   taken from the local valid/ready port, parked on data_o, and announced to
//   the foreign domain with a level on req_o. The foreign ack_i is brought into
//   clk_i through a SYNC_STAGES flop chain before the FSM looks at it.
// Ports
//   clk_i       local clock, rising edge
//   rst_ni      asynchronous active-low reset
//   in_valid_i  local word present on in_data_i
//   in_data_i   local word
//   in_ready_o  word can be accepted this cycle (idle and no ack still high)
//   req_o       registered request level to the foreign domain
//   data_o      registered crossing data, changes only on accept
//   ack_i       asynchronous acknowledge from the foreign domain
//   busy_o      handshake in progress
//   done_o      one-cycle pulse when the handshake completes
//   err_o       sticky phase-timeout flag (TIMEOUT_CYC > 0 only)
module cdc_handshake_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  // A disabled timeout still gets a 1-bit counter so the ports and flops stay legal.
  localparam int              CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [1:0]             state_q, state_d;
  logic                   req_q, req_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc_s;
  logic                   ack_s;
  logic                   in_ready_s;
  logic                   phase_s;

  assign ack_s      = ack_sync_q[SYNC_STAGES-1];
  // A still-high ack from the previous transfer (or from before a reset) blocks new work.
  assign in_ready_s = (state_q == ST_IDLE) && !ack_s;
  assign phase_s    = (state_q == ST_REQ) || (state_q == ST_RELEASE);
  // Saturating increment so a very long wait never wraps and re-arms the timeout.
  assign cnt_inc_s  = (cnt_q == CNT_LIM) ? cnt_q : (cnt_q + CNT_ONE);

  // Shift ack_i into the synchronizer; stage 0 is the only flop that sees the async input.
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_i};
  end

  // Handshake FSM, data capture, phase counter and sticky timeout flag.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i && in_ready_s) begin
          data_d  = in_data_i;
          req_d   = 1'b1;
          state_d = ST_REQ;
          cnt_d   = '0;
        end else begin
          req_d   = 1'b0;
        end
      end
      ST_REQ: begin
        // A falling ack_i here is simply not an ack; only a high ack_s advances.
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
    // The FSM keeps waiting after a timeout; the flag only reports it.
    if ((TIMEOUT_CYC > 0) && phase_s && (cnt_d == CNT_LIM)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers; reset drops req_o immediately even mid-handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_sync_q <= '0;
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ack_sync_q <= ack_sync_d;
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready_o = in_ready_s;
  assign req_o      = req_q;
  assign data_o     = data_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: a foreign-domain responder with random,
// non-clock-aligned ack timing, a monitor recording every request's data word
// and every done pulse, and per-scenario tasks comparing against the word
// queue each scenario sends and the documented cycle latencies.
module tb_cdc_handshake_tx;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready_o;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic          ack_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;
  bit resp_en = 1'b0;
  int done_cnt = 0;
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] exp_q[$];
  logic          req_prev = 1'b0;
  logic          busy_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  cdc_handshake_tx #(.DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready_o), .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Monitor: record word at each req rise, count done pulses, data hold while busy.
  initial forever begin
    @(posedge clk); #1;
    if (rst_ni) begin
      if (req_o && !req_prev) obs_q.push_back(data_o);
      if (done_o) done_cnt++;
      if (busy_prev) begin
        checks++;
        if (data_o !== data_prev) begin
          errors++;
          $display("FAIL data_hold: data_o=%h expected %h while busy", data_o, data_prev);
        end
      end
    end
    req_prev  = req_o;
    busy_prev = busy_o;
    data_prev = data_o;
  end

  // Foreign-domain responder: ack after a random delay, release after another.
  initial begin
    int d;
    forever begin
      wait (resp_en && req_o);
      d = 10 * $urandom_range(0, 3) + $urandom_range(1, 9);
      #(d); ack_i = 1'b1;
      wait (!req_o);
      d = 10 * $urandom_range(0, 3) + $urandom_range(1, 9);
      #(d); ack_i = 1'b0;
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a word and hold it until an edge where in_ready_o was high.
  task automatic drive_word(input logic [DW-1:0] w);
    int guard = 0;
    bit rdy;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      rdy = in_ready_o;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 300);
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL accept_timeout: word %h ready=%b expected 1 within 300 cycles", w, rdy);
    end
  endtask

  task automatic wait_done(input int n);
    int guard = 0;
    while (done_cnt < n && guard < 400) begin tick(1); guard++; end
    checks++;
    if (done_cnt < n) begin
      errors++;
      $display("FAIL done_timeout: done count=%0d expected %0d", done_cnt, n);
    end
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL rst_req: req_o=%b expected 0", req_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rst_data: data_o=%h expected 00", data_o); end
    checks++; if (done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_flags: done=%b err=%b busy=%b expected 000", done_o, err_o, busy_o); end
    rst_ni = 1'b1;
    tick(1);
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: in_ready_o=%b expected 1", in_ready_o); end
    drive_word(8'h3C);
    in_valid = 1'b0;
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL rst_pre_req: req_o=%b expected 1", req_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (req_o !== 1'b0 || data_o !== 8'h00 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_async: req=%b data=%h busy=%b expected 0 00 0", req_o, data_o, busy_o); end
    tick(1);
    rst_ni = 1'b1;
    tick(1);
    checks++; if (in_ready_o !== 1'b1 || req_o !== 1'b0) begin errors++; $display("FAIL rst_release: ready=%b req=%b expected 1 0", in_ready_o, req_o); end
  endtask

  task automatic test_single();
    done_cnt = 0;
    drive_word(8'hA5);
    in_valid = 1'b0;
    checks++; if (req_o !== 1'b1 || data_o !== 8'hA5) begin errors++; $display("FAIL single_req: req=%b data=%h expected 1 a5", req_o, data_o); end
    checks++; if (busy_o !== 1'b1 || in_ready_o !== 1'b0) begin errors++; $display("FAIL single_busy: busy=%b ready=%b expected 1 0", busy_o, in_ready_o); end
    tick(3);
    ack_i = 1'b1;
    tick(SS);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL single_req_hold: req_o=%b expected 1 %0d cycles after ack", req_o, SS); end
    tick(1);
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL single_req_fall: req=%b busy=%b expected 0 1", req_o, busy_o); end
    ack_i = 1'b0;
    tick(SS);
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL single_early_done: done=%b busy=%b expected 0 1", done_o, busy_o); end
    tick(1);
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL single_done: done=%b busy=%b ready=%b expected 1 0 1", done_o, busy_o, in_ready_o); end
    tick(1);
    checks++; if (done_o !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL single_pulse: done=%b count=%0d expected 0 1", done_o, done_cnt); end
    checks++; if (data_o !== 8'hA5 || err_o !== 1'b0) begin errors++; $display("FAIL single_after: data=%h err=%b expected a5 0", data_o, err_o); end
  endtask

  // Send exp_q through the responder and compare the handshakes seen.
  task automatic run_stream(input bit gaps, input string name);
    done_cnt = 0;
    obs_q.delete();
    resp_en = 1'b1;
    foreach (exp_q[i]) begin
      drive_word(exp_q[i]);
      if (gaps) begin
        in_valid = 1'b0;
        tick($urandom_range(0, 3));
      end
    end
    in_valid = 1'b0;
    wait_done(exp_q.size());
    tick(6);
    resp_en = 1'b0;
    checks++; if (done_cnt != exp_q.size() || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count: done=%0d reqs=%0d expected %0d", name, done_cnt, obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_word%0d: got %h expected %h", name, i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL %s_end: err=%b busy=%b expected 0 0", name, err_o, busy_o); end
  endtask

  task automatic test_back_to_back();
    exp_q = '{8'h11, 8'h22, 8'h33};
    run_stream(1'b0, "b2b");
  endtask

  task automatic test_jitter();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(DW'($urandom));
    run_stream(1'b1, "jitter");
  endtask

  task automatic test_timeout();
    int guard = 0;
    done_cnt = 0;
    drive_word(8'h5C);
    in_valid = 1'b0;
    tick(TO - 1);
    checks++; if (err_o !== 1'b0 || req_o !== 1'b1) begin errors++; $display("FAIL to_early: err=%b req=%b expected 0 1", err_o, req_o); end
    tick(1);
    checks++; if (err_o !== 1'b1 || req_o !== 1'b1) begin errors++; $display("FAIL to_set: err=%b req=%b expected 1 1", err_o, req_o); end
    tick(10);
    checks++; if (err_o !== 1'b1 || req_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL to_wait: err=%b req=%b busy=%b expected 1 1 1", err_o, req_o, busy_o); end
    ack_i = 1'b1;
    while (req_o && guard < 20) begin tick(1); guard++; end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL to_late_ack: req_o=%b expected 0", req_o); end
    ack_i = 1'b0;
    wait_done(1);
    checks++; if (err_o !== 1'b1 || data_o !== 8'h5C) begin errors++; $display("FAIL to_sticky: err=%b data=%h expected 1 5c", err_o, data_o); end
  endtask

  task automatic test_stale_ack();
    drive_word(8'h77);
    in_valid = 1'b0;
    ack_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0 || data_o !== 8'h00) begin errors++; $display("FAIL stale_rst: req=%b busy=%b err=%b data=%h expected 0 0 0 00", req_o, busy_o, err_o, data_o); end
    tick(1);
    rst_ni = 1'b1;
    tick(SS);
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL stale_block: in_ready_o=%b expected 0", in_ready_o); end
    in_valid = 1'b1;
    in_data  = 8'h99;
    tick(4);
    checks++; if (in_ready_o !== 1'b0 || req_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL stale_ignore: ready=%b req=%b busy=%b expected 0 0 0", in_ready_o, req_o, busy_o); end
    ack_i = 1'b0;
    tick(1);
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL stale_one: in_ready_o=%b expected 0", in_ready_o); end
    tick(1);
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL stale_free: in_ready_o=%b expected 1", in_ready_o); end
    tick(1);
    checks++; if (req_o !== 1'b1 || data_o !== 8'h99) begin errors++; $display("FAIL stale_accept: req=%b data=%h expected 1 99", req_o, data_o); end
    in_valid = 1'b0;
    done_cnt = 0;
    resp_en = 1'b1;
    wait_done(1);
    tick(2);
    resp_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_jitter();
    test_timeout();
    test_stale_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
